// File: rtl/laplace_stream_ctrl_pkg.sv
// Shared definitions for the Laplace stream controller: FSM encoding, pixel limits
// and the counter-width helper used to size the row/column counters.
package laplace_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int PIX_W_DEFAULT = 8;
    localparam int PIX_MAX       = (1 << PIX_W_DEFAULT) - 1;

    // Bits needed to index 0..value-1; never less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    function automatic int pix_max(input int pix_w);
        return (1 << pix_w) - 1;
    endfunction

endpackage

// File: rtl/laplace_line_buffer.sv
// Two-line pixel store plus tap registers; presents N/W/C/E of the cross centred one
// row up and one column left of the pixel currently being written.
module laplace_line_buffer
    import laplace_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int PIX_W = 8,
    parameter int COL_W = clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] pixel,
    output logic [PIX_W-1:0] north,
    output logic [PIX_W-1:0] west,
    output logic [PIX_W-1:0] centre,
    output logic [PIX_W-1:0] east
);

    logic [PIX_W-1:0] row1_q [IMG_W];
    logic [PIX_W-1:0] row2_q [IMG_W];
    logic [PIX_W-1:0] north_q, north_d;
    logic [PIX_W-1:0] centre_q, centre_d;
    logic [PIX_W-1:0] west_q, west_d;

    // Taps capture column c-1 values while column c is written, so they line up next time.
    always_comb begin
        north_d  = north_q;
        centre_d = centre_q;
        west_d   = west_q;
        if (shift_en) begin
            north_d  = row2_q[col];
            centre_d = row1_q[col];
            west_d   = centre_q;
        end
    end

    always_ff @(posedge clk) begin
        north_q  <= north_d;
        centre_q <= centre_d;
        west_q   <= west_d;
        if (shift_en) begin
            row1_q[col] <= pixel;
            row2_q[col] <= row1_q[col];
        end
    end

    assign north  = north_q;
    assign west   = west_q;
    assign centre = centre_q;
    assign east   = row1_q[col];

endmodule

// File: rtl/laplace_stream_ctrl.sv
// Raster-stream controller for an external 5-tap cross Laplace datapath.
// Optional saturation statistics counter enabled by LAPLACE_CTRL_STATS_EN.
module laplace_stream_ctrl
    import laplace_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic [PIX_W-1:0] win_b,
    output logic [PIX_W-1:0] win_d,
    output logic [PIX_W-1:0] win_e,
    output logic [PIX_W-1:0] win_f,
    output logic [PIX_W-1:0] win_h,
    input  logic [PIX_W:0]   lap_s,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_pixel,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
`ifdef LAPLACE_CTRL_STATS_EN
    ,
    output logic [15:0]      sat_cnt
`endif
);

    localparam int COL_W = clog2(IMG_W);
    localparam int ROW_W = clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [PIX_W-1:0] PIX_TOP  = PIX_W'(pix_max(PIX_W));

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
    logic             done_q, done_d;
    logic [PIX_W-1:0] south_q, south_d;
    logic [PIX_W-1:0] tap_n, tap_w, tap_c, tap_e;
    logic             accept, win_en, out_hs, last_pix;

    function automatic logic [PIX_W-1:0] clamp_pix(input logic [PIX_W:0] s);
        return (s > {1'b0, PIX_TOP}) ? PIX_TOP : s[PIX_W-1:0];
    endfunction

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign win_en   = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign out_hs   = out_valid_q && out_ready;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    laplace_line_buffer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .COL_W (COL_W)
    ) u_line_buf (
        .clk      (clk),
        .shift_en (accept),
        .col      (col_q),
        .pixel    (in_pixel),
        .north    (tap_n),
        .west     (tap_w),
        .centre   (tap_c),
        .east     (tap_e)
    );

    // Window is forced to zero outside an interior-producing acceptance.
    assign win_b = win_en ? tap_n   : '0;
    assign win_d = win_en ? tap_w   : '0;
    assign win_e = win_en ? tap_c   : '0;
    assign win_f = win_en ? tap_e   : '0;
    assign win_h = win_en ? south_q : '0;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        south_d     = accept ? in_pixel : south_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_pix) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh result always wins over clearing on handshake.
        if (win_en) begin
            out_valid_d = 1'b1;
            out_pixel_d = clamp_pix(lap_s);
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        south_q <= south_d;
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

`ifdef LAPLACE_CTRL_STATS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (state_q == ST_IDLE && start) begin
            sat_cnt_d = '0;
        end else if (out_hs && (out_pixel_q == '0 || out_pixel_q == PIX_TOP)
                     && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_laplace_stream_ctrl.sv
// Bench for laplace_stream_ctrl on an 8x8 frame with an external datapath model.
module tb_laplace_stream_ctrl;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_pixel = '0;
    logic       in_ready;
    logic [7:0] win_b, win_d, win_e, win_f, win_h;
    logic [8:0] lap_s;
    logic       out_valid;
    logic [7:0] out_pixel;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
`ifdef LAPLACE_CTRL_STATS_EN
    logic [15:0] sat_cnt;
`endif

    laplace_stream_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_pixel  (in_pixel),
        .in_ready  (in_ready),
        .win_b     (win_b),
        .win_d     (win_d),
        .win_e     (win_e),
        .win_f     (win_f),
        .win_h     (win_h),
        .lap_s     (lap_s),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef LAPLACE_CTRL_STATS_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External datapath: neighbours minus four times centre, clamped to 0..511.
    function automatic logic [8:0] dp(input int b, input int d, input int e,
                                      input int f, input int h);
        int s;
        s = b + d + f + h - 4 * e;
        if (s < 0) s = 0;
        if (s > 511) s = 511;
        return 9'(s);
    endfunction

    assign lap_s = dp(int'(win_b), int'(win_d), int'(win_e), int'(win_f), int'(win_h));

    int errors = 0;
    int checks = 0;
    int pix [H][W];
    int exp_q [$];
    int exp_sat;

    typedef struct {
        string name;
        int    pat;
        int    rdy;
        int    vpct;
        bit    pulse;
        int    exp_outs;
        int    exp_first;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic gen_pattern(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0: pix[r][c] = 10;
                    1: pix[r][c] = (r == 3 && c == 3) ? 0 : 50;
                    2: pix[r][c] = (r == 3 && c == 3) ? 255 : 0;
                    3: pix[r][c] = ((r + c) % 2 == 1) ? 255 : 0;
                    4: pix[r][c] = (3 * r * r + 2 * c * c + r * c) % 256;
                    default: pix[r][c] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    // Reference: every interior pixel in raster order, datapath clamp then 8-bit clamp.
    task automatic build_expect();
        int s;
        exp_q.delete();
        exp_sat = 0;
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                s = pix[r-1][c] + pix[r][c-1] + pix[r][c+1] + pix[r+1][c] - 4 * pix[r][c];
                if (s < 0) s = 0;
                if (s > 511) s = 511;
                if (s > 255) s = 255;
                exp_q.push_back(s);
                if (s == 0 || s == 255) exp_sat++;
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        int idx, got, cyc, first_got;
        bit ov_expected;
        gen_pattern(v.pat);
        build_expect();
        idx = 0; got = 0; cyc = 0; first_got = -1; ov_expected = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1 check({v.name, " busy_after_start"}, int'(busy), 1);
        while (got < exp_q.size() && cyc < 3000) begin
            in_valid  = (idx < W * H) && ($urandom_range(99) < v.vpct);
            in_pixel  = in_valid ? 8'(pix[idx / W][idx % W]) : 8'd0;
            case (v.rdy)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(1) == 1);
            endcase
            start = v.pulse && busy && (cyc % 5 == 2);
            #1;
            if (ov_expected) check({v.name, " out_valid_latency"}, int'(out_valid), 1);
            ov_expected = 1'b0;
            if (out_valid && !out_ready) check({v.name, " stall_in_ready"}, int'(in_ready), 0);
            if (out_valid && out_ready) begin
                check({v.name, " out_pixel"}, int'(out_pixel), exp_q[got]);
                if (got == 0) first_got = int'(out_pixel);
                got++;
            end
            if (in_valid && in_ready) begin
                if (idx / W >= 2 && idx % W >= 2) ov_expected = 1'b1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (cyc >= 3000) check({v.name, " frame_timeout"}, got, exp_q.size());
        check({v.name, " out_count"}, got, v.exp_outs);
        check({v.name, " pixels_accepted"}, idx, W * H);
        if (v.exp_first >= 0) check({v.name, " first_output"}, first_got, v.exp_first);
        #1;
        check({v.name, " done_pulse"}, int'(done), 1);
        check({v.name, " busy_clear"}, int'(busy), 0);
        check({v.name, " out_valid_clear"}, int'(out_valid), 0);
`ifdef LAPLACE_CTRL_STATS_EN
        check({v.name, " sat_cnt"}, int'(sat_cnt), exp_sat);
`endif
        @(negedge clk); #1;
        check({v.name, " done_one_cycle"}, int'(done), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_ready"}, int'(in_ready), 0);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " out_pixel"}, int'(out_pixel), 0);
        check({tag, " win_or"}, int'(win_b | win_d | win_e | win_f | win_h), 0);
    endtask

    initial begin
        int idx, cyc;
        vecs[0] = '{"uniform10",   0, 0, 100, 1'b0, 36, 0};
        vecs[1] = '{"hot_zero",    1, 0, 100, 1'b0, 36, 0};
        vecs[2] = '{"hot_255",     2, 0, 100, 1'b0, 36, 0};
        vecs[3] = '{"checker",     3, 0, 100, 1'b0, 36, 255};
        vecs[4] = '{"ramp_toggle", 4, 1, 60,  1'b0, 36, 10};
        vecs[5] = '{"random",      5, 2, 70,  1'b1, 36, -1};
        vecs[6] = '{"ramp_pulse",  4, 0, 100, 1'b1, 36, 10};

        repeat (3) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid while idle must not be taken
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = 8'(i + 100);
            #1;
            check("idle_in_ready", int'(in_ready), 0);
            check("idle_busy", int'(busy), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;

        for (int t = 0; t < 7; t++) run_frame(vecs[t]);

        // abort a frame after 20 pixels, then a clean frame must match the model
        gen_pattern(4);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx = 0; cyc = 0;
        out_ready = 1'b1;
        while (idx < 20 && cyc < 200) begin
            in_valid = 1'b1;
            in_pixel = 8'(pix[idx / W][idx % W]);
            #1;
            if (in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        check("abort_fed", idx, 20);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vecs[6]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
